sdram_model: RTL and testbench



---
 rtl/sdram_model.sv | 188 ++++++++++++++++++
 tb/tb_sdram_model.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sdram_model.sv
// sdram_model: cycle-accurate SDRAM responder with burst FSM, CL pipeline and protocol checks.
// Optional per-bank tRCD/tRP checking is enabled by defining SDRAM_MODEL_TIMING_CHK_EN.
module sdram_model #(
    parameter int ROW_BITS = 11,
    parameter int COL_BITS = 8,
    parameter int TRCD = 2,
    parameter int TRP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_cke,
    input  logic        sdram_cs_n,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic [1:0]  sdram_ba,
    input  logic [10:0] sdram_addr,
    input  logic [31:0] sdram_dq_in,
    output logic [31:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    output logic        err_flag,
    output logic [2:0]  err_code,
    output logic [15:0] refresh_cnt
);
    localparam int AW = 2 + ROW_BITS + COL_BITS;
    localparam logic [2:0] C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100, C_BT = 3'b110;
    localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000, C_NOP = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

    state_t               r_state, w_state_nx;
    logic [31:0]          r_mem [2**AW];
    logic [ROW_BITS-1:0]  r_row [4];
    logic [3:0]           r_open;
    logic                 r_mode_ok, r_cl3;
    logic [COL_BITS-1:0]  r_mask, r_col, r_cnt;
    logic [1:0]           r_bank;
    logic [31:0]          r_p0, r_p1;
    logic                 r_v0, r_v1;
    logic                 r_err_flag;
    logic [2:0]           r_err_code;
    logic [15:0]          r_ref_cnt;

    logic [2:0]           w_cmd, w_ferr, w_terr, w_code;
    logic                 w_ok, w_rw, w_pre_hit, w_we, w_bl_ok, w_cl_ok;
    logic [COL_BITS-1:0]  w_col_in, w_mask_in, w_col_nx, w_cnt_nx, w_wcol;
    logic [1:0]           w_bank_nx, w_wbank;
    logic [31:0]          w_rdata;

    function automatic logic [COL_BITS-1:0] f_next(input logic [COL_BITS-1:0] c, input logic [COL_BITS-1:0] m);
        return (c & ~m) | ((c + 1'b1) & m);
    endfunction

    assign w_cmd     = (sdram_cke && !sdram_cs_n) ? {sdram_ras_n, sdram_cas_n, sdram_we_n} : C_NOP;
    assign w_col_in  = sdram_addr[COL_BITS-1:0];
    assign w_rw      = (w_cmd == C_RD) || (w_cmd == C_WR);
    assign w_bl_ok   = (sdram_addr[2:0] == 3'd7) || !sdram_addr[2];
    assign w_cl_ok   = (sdram_addr[6:4] == 3'd2) || (sdram_addr[6:4] == 3'd3);
    assign w_mask_in = (sdram_addr[2:0] == 3'd7) ? '1 : COL_BITS'((32'd1 << sdram_addr[1:0]) - 32'd1);

    assign w_ferr = (!r_mode_ok && (w_rw || w_cmd == C_ACT || w_cmd == C_BT)) ? 3'd3 :
                    (w_rw && !r_open[sdram_ba])                                ? 3'd1 :
                    (w_cmd == C_ACT && r_open[sdram_ba])                       ? 3'd2 :
                    (w_cmd == C_REF && |r_open)                                ? 3'd4 :
                    (w_cmd == C_LMR && !(w_bl_ok && w_cl_ok))                  ? 3'd5 : 3'd0;
    assign w_ok      = (w_ferr == 3'd0);
    assign w_code    = w_ok ? w_terr : w_ferr;
    assign w_pre_hit = w_ok && (w_cmd == C_PRE) && (sdram_addr[10] || sdram_ba == r_bank);

`ifdef SDRAM_MODEL_TIMING_CHK_EN
    // One counter per bank covers both tRCD and tRP: the bank's open/closed state tells which applies.
    logic [7:0] r_tmr [4];
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (rst)
                r_tmr[b] <= 8'd0;
            else if (sdram_cke) begin
                if (w_ok && w_cmd == C_ACT && sdram_ba == 2'(b))
                    r_tmr[b] <= 8'(TRCD - 1);
                else if (w_ok && w_cmd == C_PRE && (sdram_addr[10] || sdram_ba == 2'(b)))
                    r_tmr[b] <= 8'(TRP - 1);
                else if (r_tmr[b] != 8'd0)
                    r_tmr[b] <= r_tmr[b] - 8'd1;
            end
        end
    end
    assign w_terr = (w_ok && w_rw && r_tmr[sdram_ba] != 8'd0)           ? 3'd6 :
                    (w_ok && w_cmd == C_ACT && r_tmr[sdram_ba] != 8'd0) ? 3'd7 : 3'd0;
`else
    assign w_terr = 3'd0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_col_nx   = r_col;
        w_cnt_nx   = r_cnt;
        w_bank_nx  = r_bank;
        w_we       = 1'b0;
        w_wcol     = r_col;
        w_wbank    = r_bank;
        if (w_ok && w_cmd == C_WR) begin
            w_we       = 1'b1;
            w_wcol     = w_col_in;
            w_wbank    = sdram_ba;
            w_bank_nx  = sdram_ba;
            w_col_nx   = f_next(w_col_in, r_mask);
            w_cnt_nx   = COL_BITS'(1);
            w_state_nx = (r_mask == '0) ? S_IDLE : S_WR;
        end else if (w_ok && w_cmd == C_RD) begin
            w_bank_nx  = sdram_ba;
            w_col_nx   = w_col_in;
            w_cnt_nx   = '0;
            w_state_nx = S_RD;
        end else if ((w_ok && w_cmd == C_BT) || w_pre_hit) begin
            w_state_nx = S_IDLE;
        end else if (r_state != S_IDLE) begin
            w_we       = (r_state == S_WR);
            w_col_nx   = f_next(r_col, r_mask);
            w_cnt_nx   = r_cnt + 1'b1;
            w_state_nx = (r_cnt == r_mask) ? S_IDLE : r_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_open     <= 4'b0;
            r_mode_ok  <= 1'b0;
            r_mask     <= '0;
            r_cl3      <= 1'b0;
            r_bank     <= 2'd0;
            r_col      <= '0;
            r_cnt      <= '0;
            r_err_flag <= 1'b0;
            r_err_code <= 3'd0;
            r_ref_cnt  <= 16'd0;
        end else if (sdram_cke) begin
            r_state <= w_state_nx;
            r_col   <= w_col_nx;
            r_cnt   <= w_cnt_nx;
            r_bank  <= w_bank_nx;
            if (w_code != 3'd0 && !r_err_flag) begin
                r_err_flag <= 1'b1;
                r_err_code <= w_code;
            end
            if (w_ok && w_cmd == C_ACT) begin
                r_open[sdram_ba] <= 1'b1;
                r_row[sdram_ba]  <= sdram_addr[ROW_BITS-1:0];
            end
            if (w_ok && w_cmd == C_PRE)
                r_open <= sdram_addr[10] ? 4'b0 : r_open & ~(4'b1 << sdram_ba);
            if (w_ok && w_cmd == C_REF && r_ref_cnt != 16'hFFFF)
                r_ref_cnt <= r_ref_cnt + 16'd1;
            if (w_ok && w_cmd == C_LMR) begin
                r_mask    <= w_mask_in;
                r_cl3     <= sdram_addr[4];
                r_mode_ok <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && sdram_cke && w_we)
            r_mem[{w_wbank, r_row[w_wbank], w_wcol}] <= sdram_dq_in;
    end

    // Stage 0 holds the word read during the last RD cycle; CL=3 adds one more stage.
    assign w_rdata = r_mem[{r_bank, r_row[r_bank], r_col}];
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_p0 <= 32'd0;
            r_p1 <= 32'd0;
        end else if (sdram_cke) begin
            r_v0 <= (r_state == S_RD);
            r_p0 <= (r_state == S_RD) ? w_rdata : 32'd0;
            r_v1 <= r_v0;
            r_p1 <= r_p0;
        end
    end

    assign sdram_dq_oe  = r_cl3 ? r_v1 : r_v0;
    assign sdram_dq_out = r_cl3 ? r_p1 : r_p0;
    assign err_flag     = r_err_flag;
    assign err_code     = r_err_code;
    assign refresh_cnt  = r_ref_cnt;
endmodule

// File: tb/tb_sdram_model.sv
// tb_sdram_model: directed checks of sdram_model bursts, CAS latency, errors and refresh counting.
module tb_sdram_model;
    localparam logic [2:0] ACT = 3'b011, RD = 3'b101, WR = 3'b100, BT = 3'b110;
    localparam logic [2:0] PRE = 3'b010, REF = 3'b001, LMR = 3'b000, NOP = 3'b111;

    logic        clk = 1'b0, rst = 1'b1, cke = 1'b1, cs_n = 1'b0;
    logic        ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0]  ba = 2'd0;
    logic [10:0] addr = 11'd0;
    logic [31:0] dq_in = 32'd0;
    logic [31:0] dq_out;
    logic        dq_oe, err_flag;
    logic [2:0]  err_code;
    logic [15:0] refresh_cnt;
    int          n_cmp = 0, n_bad = 0;

    sdram_model #(.ROW_BITS(5), .COL_BITS(8), .TRCD(2), .TRP(2)) dut (
        .clk(clk), .rst(rst), .sdram_cke(cke), .sdram_cs_n(cs_n), .sdram_ras_n(ras_n),
        .sdram_cas_n(cas_n), .sdram_we_n(we_n), .sdram_ba(ba), .sdram_addr(addr),
        .sdram_dq_in(dq_in), .sdram_dq_out(dq_out), .sdram_dq_oe(dq_oe),
        .err_flag(err_flag), .err_code(err_code), .refresh_cnt(refresh_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic [2:0] c, input logic [1:0] b, input logic [10:0] a, input logic [31:0] d);
        {ras_n, cas_n, we_n} = c;
        ba = b;
        addr = a;
        dq_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tick(NOP, 0, 0, 0);
        tick(NOP, 0, 0, 0);
        rst = 1'b0;
        chk("rst_oe", 32'(dq_oe), 0);
        chk("rst_dq", dq_out, 0);
        chk("rst_flag", 32'(err_flag), 0);
        chk("rst_code", 32'(err_code), 0);
        chk("rst_ref", 32'(refresh_cnt), 0);

        repeat (3) tick(REF, 0, 0, 0);
        chk("ref3_cnt", 32'(refresh_cnt), 3);
        chk("ref3_flag", 32'(err_flag), 0);

        tick(LMR, 0, 11'h027, 0);
        tick(ACT, 1, 11'h012, 0);
        tick(NOP, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(i == 0 ? WR : NOP, 1, 0, 32'h1000 + i);
        tick(BT, 0, 0, 0);
        tick(RD, 1, 0, 0);
        chk("fp_oe0", 32'(dq_oe), 0);
        for (int i = 0; i < 4; i++) begin
            tick(i == 3 ? BT : NOP, 0, 0, 0);
            chk("fp_oe", 32'(dq_oe), 1);
            chk("fp_dq", dq_out, 32'h1000 + i);
        end
        tick(NOP, 0, 0, 0);
        chk("fp_oe_end", 32'(dq_oe), 0);
        chk("fp_flag", 32'(err_flag), 0);

        tick(LMR, 0, 11'h032, 0);
        tick(WR, 1, 11'h006, 32'hAAAA0001);
        tick(NOP, 0, 0, 32'hAAAA0002);
        tick(NOP, 0, 0, 32'hAAAA0003);
        tick(NOP, 0, 0, 32'hAAAA0004);
        tick(RD, 1, 11'h004, 0);
        tick(NOP, 0, 0, 0);
        chk("bl4_oe1", 32'(dq_oe), 0);
        tick(NOP, 0, 0, 0);
        chk("bl4_oe2", 32'(dq_oe), 1);
        chk("bl4_w0", dq_out, 32'hAAAA0003);
        tick(NOP, 0, 0, 0);
        chk("bl4_w1", dq_out, 32'hAAAA0004);
        tick(NOP, 0, 0, 0);
        chk("bl4_w2", dq_out, 32'hAAAA0001);
        tick(NOP, 0, 0, 0);
        chk("bl4_w3", dq_out, 32'hAAAA0002);
        tick(NOP, 0, 0, 0);
        chk("bl4_oe_end", 32'(dq_oe), 0);

        tick(LMR, 0, 11'h037, 0);
        tick(RD, 1, 0, 0);
        tick(NOP, 0, 0, 0);
        tick(NOP, 0, 0, 0);
        chk("pre_w0", dq_out, 32'h1000);
        tick(PRE, 1, 0, 0);
        chk("pre_w1", dq_out, 32'h1001);
        tick(NOP, 0, 0, 0);
        chk("pre_oe2", 32'(dq_oe), 1);
        chk("pre_w2", dq_out, 32'h1002);
        tick(NOP, 0, 0, 0);
        chk("pre_oe_end", 32'(dq_oe), 0);
        tick(NOP, 0, 0, 0);
        chk("pre_oe_idle", 32'(dq_oe), 0);
        chk("pre_flag", 32'(err_flag), 0);

        tick(ACT, 0, 0, 0);
        tick(REF, 0, 0, 0);
        chk("ref_open_code", 32'(err_code), 4);
        chk("ref_open_flag", 32'(err_flag), 1);
        chk("ref_open_cnt", 32'(refresh_cnt), 3);

        tick(RD, 0, 0, 0);
        tick(NOP, 0, 0, 0);
        tick(NOP, 0, 0, 0);
        chk("mid_oe", 32'(dq_oe), 1);
        rst = 1'b1;
        tick(NOP, 0, 0, 0);
        chk("mid_rst_oe", 32'(dq_oe), 0);
        chk("mid_rst_flag", 32'(err_flag), 0);
        chk("mid_rst_ref", 32'(refresh_cnt), 0);
        rst = 1'b0;
        tick(NOP, 0, 0, 0);
        chk("mid_drain_oe", 32'(dq_oe), 0);

        tick(LMR, 0, 11'h020, 0);
        tick(RD, 2, 0, 0);
        chk("closed_flag", 32'(err_flag), 1);
        chk("closed_code", 32'(err_code), 1);
        tick(NOP, 0, 0, 0);
        chk("closed_oe1", 32'(dq_oe), 0);
        tick(NOP, 0, 0, 0);
        chk("closed_oe2", 32'(dq_oe), 0);
        tick(ACT, 0, 11'h001, 0);
        tick(ACT, 0, 11'h002, 0);
        chk("first_code", 32'(err_code), 1);

        rst = 1'b1;
        tick(NOP, 0, 0, 0);
        rst = 1'b0;
        tick(LMR, 0, 11'h020, 0);
        tick(ACT, 3, 11'h005, 0);
        tick(NOP, 0, 0, 0);
        tick(NOP, 0, 0, 0);
        tick(WR, 3, 11'h009, 32'h0000BEEF);
        tick(PRE, 3, 0, 0);
        tick(NOP, 0, 0, 0);
        tick(ACT, 3, 11'h005, 0);
        chk("trp_ok_flag", 32'(err_flag), 0);
        tick(RD, 3, 11'h009, 0);
`ifdef SDRAM_MODEL_TIMING_CHK_EN
        chk("trcd_flag", 32'(err_flag), 1);
        chk("trcd_code", 32'(err_code), 6);
`else
        chk("trcd_flag", 32'(err_flag), 0);
        chk("trcd_code", 32'(err_code), 0);
`endif
        tick(NOP, 0, 0, 0);
        chk("trcd_oe", 32'(dq_oe), 1);
        chk("trcd_dq", dq_out, 32'h0000BEEF);
        tick(NOP, 0, 0, 0);
        chk("trcd_oe_end", 32'(dq_oe), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
